// File: rtl/bus_activity_if.sv
// bus_activity_if: observed arbiter request/grant vectors and bus utilization line
interface bus_activity_if #(parameter int NUM_MASTERS = 12);
  logic                   bus_util;
  logic [NUM_MASTERS-1:0] m_reqs;
  logic [NUM_MASTERS-1:0] m_grants;
  modport master (output bus_util, m_reqs, m_grants);
  modport slave (input bus_util, m_reqs, m_grants);
endinterface

// File: rtl/bus_activity_monitor.sv
// bus_activity_monitor: passive per-window utilization, per-master transaction and grant-latency statistics
module bus_activity_monitor #(
  parameter int NUM_MASTERS   = 12,
  parameter int WINDOW_CYCLES = 100
) (
  input  logic          clk,
  input  logic          rstn,
  bus_activity_if.slave bus,
  input  logic          clear,
  input  logic [3:0]    sel_master,
  output logic [7:0]    util_pct,
  output logic [7:0]    peak_pct,
  output logic [7:0]    txn_count,
  output logic [7:0]    total_txn,
  output logic [7:0]    max_wait,
  output logic          window_done
);
  logic                   busy, win_end;
  logic [NUM_MASTERS-1:0] g_prev, g_edge;
  logic [7:0]             txn [NUM_MASTERS];
  logic [7:0]             wt [NUM_MASTERS];
  logic [7:0]             win_cnt, acc, util_next, total_next, max_next, sel_txn;
  logic [8:0]             sum;
  assign busy      = ~bus.bus_util;
  assign g_edge    = bus.m_grants & ~g_prev;
  assign win_end   = win_cnt == 8'(WINDOW_CYCLES - 1);
  assign util_next = acc + {7'd0, busy};
  always_comb begin
    sum      = {1'b0, total_txn};
    max_next = max_wait;
    sel_txn  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      sum      = sum + {8'd0, g_edge[i]};
      max_next = g_edge[i] && wt[i] > max_next ? wt[i] : max_next;
      sel_txn  = sel_master == 4'(i) ? txn[i] : sel_txn;
    end
    total_next = sum[8] ? 8'hff : sum[7:0];
  end
  // clear outranks grant edges and window end, but g_prev keeps tracking so held grants stay uncounted
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      g_prev      <= '0;
      win_cnt     <= '0;
      acc         <= '0;
      util_pct    <= '0;
      peak_pct    <= '0;
      total_txn   <= '0;
      max_wait    <= '0;
      txn_count   <= '0;
      window_done <= 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
        txn[i] <= '0;
        wt[i]  <= '0;
      end
    end else begin
      g_prev <= bus.m_grants;
      if (clear) begin
        win_cnt     <= '0;
        acc         <= '0;
        util_pct    <= '0;
        peak_pct    <= '0;
        total_txn   <= '0;
        max_wait    <= '0;
        txn_count   <= '0;
        window_done <= 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
          txn[i] <= '0;
          wt[i]  <= '0;
        end
      end else begin
        win_cnt     <= win_end ? '0 : win_cnt + 8'd1;
        acc         <= win_end ? '0 : util_next;
        window_done <= win_end;
        util_pct    <= win_end ? util_next : util_pct;
        peak_pct    <= win_end && util_next > peak_pct ? util_next : peak_pct;
        total_txn   <= total_next;
        max_wait    <= max_next;
        txn_count   <= sel_txn;
        for (int i = 0; i < NUM_MASTERS; i++) begin
          txn[i] <= g_edge[i] && txn[i] != 8'hff ? txn[i] + 8'd1 : txn[i];
          wt[i]  <= g_edge[i] || !bus.m_reqs[i] ? '0 :
                    !bus.m_grants[i] && wt[i] != 8'hff ? wt[i] + 8'd1 : wt[i];
        end
      end
    end
endmodule

// File: tb/tb_bus_activity_monitor.sv
// tb_bus_activity_monitor: directed checks of bus_activity_monitor with immediate assertions
module tb_bus_activity_monitor;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] sel_master = 4'd0;
  logic [7:0] util_pct, peak_pct, txn_count, total_txn, max_wait;
  logic       window_done;
  int         total = 0;
  int         bad = 0;
  int         n;
  bus_activity_if #(.NUM_MASTERS(12)) bif ();
  bus_activity_monitor #(.NUM_MASTERS(12), .WINDOW_CYCLES(100)) dut (
    .clk(clk), .rstn(rstn), .bus(bif.slave), .clear(clear), .sel_master(sel_master),
    .util_pct(util_pct), .peak_pct(peak_pct), .txn_count(txn_count), .total_txn(total_txn),
    .max_wait(max_wait), .window_done(window_done)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic wait_wd(output int cnt);
    cnt = 0;
    do begin
      tick;
      cnt++;
    end while (!window_done && cnt < 400);
    chk("window_timeout", int'(window_done), 1);
  endtask
  initial begin
    bif.bus_util = 1'b1;
    bif.m_reqs   = '0;
    bif.m_grants = '0;
    #3;
    chk("rst_util", util_pct, 0);
    chk("rst_total", total_txn, 0);
    chk("rst_wd", int'(window_done), 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    wait_wd(n);
    chk("first_window_len", n, 100);
    chk("idle_util", util_pct, 0);
    bif.bus_util = 1'b0;
    repeat (37) tick;
    bif.bus_util = 1'b1;
    repeat (63) tick;
    chk("win1_done", int'(window_done), 1);
    chk("win1_util", util_pct, 37);
    chk("win1_peak", peak_pct, 37);
    bif.bus_util = 1'b0;
    repeat (12) tick;
    bif.bus_util = 1'b1;
    repeat (88) tick;
    chk("win2_done", int'(window_done), 1);
    chk("win2_util", util_pct, 12);
    chk("win2_peak", peak_pct, 37);
    tick;
    chk("wd_pulse_width", int'(window_done), 0);
    repeat (5) begin
      bif.m_grants[3] = 1'b1;
      tick;
      bif.m_grants[3] = 1'b0;
      tick;
    end
    sel_master = 4'd3;
    tick;
    chk("m3_count", txn_count, 5);
    chk("m3_total", total_txn, 5);
    bif.m_grants[3] = 1'b1;
    repeat (5) tick;
    bif.m_grants[3] = 1'b0;
    tick;
    tick;
    chk("m3_held_once", txn_count, 6);
    chk("held_total", total_txn, 6);
    sel_master = 4'd4;
    tick;
    chk("m4_zero", txn_count, 0);
    sel_master = 4'd13;
    tick;
    chk("sel13_zero", txn_count, 0);
    repeat (300) begin
      bif.m_grants[4] = 1'b1;
      tick;
      bif.m_grants[4] = 1'b0;
      tick;
    end
    sel_master = 4'd4;
    tick;
    chk("m4_sat", txn_count, 255);
    chk("total_sat", total_txn, 255);
    chk("wait_idle", max_wait, 0);
    bif.m_reqs[5] = 1'b1;
    repeat (20) tick;
    bif.m_grants[5] = 1'b1;
    tick;
    bif.m_reqs[5]   = 1'b0;
    bif.m_grants[5] = 1'b0;
    chk("wait_m5", max_wait, 20);
    bif.m_reqs[2] = 1'b1;
    repeat (6) tick;
    bif.m_grants[2] = 1'b1;
    tick;
    bif.m_reqs[2]   = 1'b0;
    bif.m_grants[2] = 1'b0;
    chk("wait_m2_smaller", max_wait, 20);
    bif.m_reqs[1] = 1'b1;
    repeat (40) tick;
    bif.m_reqs[1] = 1'b0;
    tick;
    bif.m_grants[1] = 1'b1;
    tick;
    bif.m_grants[1] = 1'b0;
    chk("wait_dropped_req", max_wait, 20);
    sel_master = 4'd3;
    wait_wd(n);
    repeat (99) tick;
    clear           = 1'b1;
    bif.m_grants[3] = 1'b1;
    bif.bus_util    = 1'b0;
    tick;
    clear        = 1'b0;
    bif.bus_util = 1'b1;
    chk("clr_wd", int'(window_done), 0);
    chk("clr_util", util_pct, 0);
    chk("clr_peak", peak_pct, 0);
    chk("clr_total", total_txn, 0);
    chk("clr_wait", max_wait, 0);
    chk("clr_txn", txn_count, 0);
    wait_wd(n);
    chk("clr_window_len", n, 100);
    chk("clr_held_txn", txn_count, 0);
    chk("clr_held_total", total_txn, 0);
    bif.m_grants[3] = 1'b0;
    tick;
    bif.m_grants[3] = 1'b1;
    tick;
    tick;
    chk("regrant_txn", txn_count, 1);
    chk("regrant_total", total_txn, 1);
    #2 rstn = 1'b0;
    #2;
    chk("async_txn", txn_count, 0);
    chk("async_total", total_txn, 0);
    chk("async_util", util_pct, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
